// File: rtl/spectral_peak_finder.sv
// ---------------------------------------------------------------------------
// spectral_peak_finder
//
// Sequential peak detector placed after the FFT magnitude stage. On start it
// latches a packed vector of per-bin squared magnitudes plus a detection
// threshold, then walks the eligible bins one per cycle keeping a running
// maximum. When the walk ends it pulses done and publishes the peak bin
// index, its magnitude and whether that magnitude is strictly above the
// threshold. All magnitudes are unsigned (sums of squares).
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   latch input_mags/threshold and begin a scan (when ready)
//   input_mags  in   buffer_size*sample_size packed bins, bin k at
//                    [sample_size*k +: sample_size]
//   threshold   in   unsigned detection threshold
//   ready       out  block accepts start this cycle
//   done        out  one-cycle pulse, results valid from this cycle on
//   peak_index  out  index of the largest eligible bin (lowest on ties)
//   peak_mag    out  magnitude of that bin
//   peak_found  out  peak_mag > threshold
// ---------------------------------------------------------------------------
module spectral_peak_finder #(
    parameter int sample_size = 16,
    parameter int buffer_size = 8,
    parameter int scan_bins   = buffer_size / 2,
    parameter int skip_dc     = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [buffer_size*sample_size-1:0] input_mags,
    input  logic [sample_size-1:0]             threshold,
    output logic                               ready,
    output logic                               done,
    output logic [$clog2(buffer_size)-1:0]     peak_index,
    output logic [sample_size-1:0]             peak_mag,
    output logic                               peak_found
);

    localparam int IW     = $clog2(buffer_size);
    localparam int F_INT  = (skip_dc != 0) ? 1 : 0;
    localparam int N_BINS = scan_bins - F_INT;

    localparam logic [IW-1:0] FIRST  = IW'(F_INT);
    localparam logic [IW-1:0] SECOND = IW'(F_INT + 1);
    localparam logic [IW-1:0] LAST   = IW'(scan_bins - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic [buffer_size*sample_size-1:0] mags_q, mags_d;
    logic [sample_size-1:0]             thr_q, thr_d;
    logic [sample_size-1:0]             max_val_q, max_val_d;
    logic [IW-1:0]                      max_idx_q, max_idx_d;
    logic [IW-1:0]                      cnt_q, cnt_d;
    logic                               ready_q, ready_d;
    logic                               done_q, done_d;
    logic [IW-1:0]                      peak_index_q, peak_index_d;
    logic [sample_size-1:0]             peak_mag_q, peak_mag_d;
    logic                               peak_found_q, peak_found_d;

    logic [sample_size-1:0]             cand_val_s;
    logic [sample_size-1:0]             first_val_s;

    // Next-state, datapath and output-register logic for the scan FSM.
    always_comb begin
        state_d      = state_q;
        mags_d       = mags_q;
        thr_d        = thr_q;
        max_val_d    = max_val_q;
        max_idx_d    = max_idx_q;
        cnt_d        = cnt_q;
        peak_index_d = peak_index_q;
        peak_mag_d   = peak_mag_q;
        peak_found_d = peak_found_q;

        cand_val_s  = mags_q[int'(cnt_q) * sample_size +: sample_size];
        first_val_s = input_mags[F_INT * sample_size +: sample_size];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mags_d    = input_mags;
                    thr_d     = threshold;
                    max_val_d = first_val_s;
                    max_idx_d = FIRST;
                    cnt_d     = SECOND;
                    if (N_BINS == 1) begin
                        // Single eligible bin: it is the peak, publish now.
                        state_d      = ST_DONE;
                        peak_index_d = FIRST;
                        peak_mag_d   = first_val_s;
                        peak_found_d = (first_val_s > threshold);
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // Strictly greater keeps the lowest index on ties.
                if (cand_val_s > max_val_q) begin
                    max_val_d = cand_val_s;
                    max_idx_d = cnt_q;
                end else begin
                    max_val_d = max_val_q;
                    max_idx_d = max_idx_q;
                end
                if (cnt_q == LAST) begin
                    // Last compare: publish so outputs are valid in the done cycle.
                    state_d      = ST_DONE;
                    cnt_d        = cnt_q;
                    peak_index_d = max_idx_d;
                    peak_mag_d   = max_val_d;
                    peak_found_d = (max_val_d > thr_q);
                end else begin
                    cnt_d = cnt_q + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mags_q       <= '0;
            thr_q        <= '0;
            max_val_q    <= '0;
            max_idx_q    <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            peak_index_q <= '0;
            peak_mag_q   <= '0;
            peak_found_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mags_q       <= mags_d;
            thr_q        <= thr_d;
            max_val_q    <= max_val_d;
            max_idx_q    <= max_idx_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            peak_index_q <= peak_index_d;
            peak_mag_q   <= peak_mag_d;
            peak_found_q <= peak_found_d;
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign peak_index = peak_index_q;
    assign peak_mag   = peak_mag_q;
    assign peak_found = peak_found_q;

endmodule

// File: tb/tb_spectral_peak_finder.sv
// ---------------------------------------------------------------------------
// Self-checking bench for spectral_peak_finder (sample_size=16,
// buffer_size=8, scan_bins=4, skip_dc=1 -> three eligible bins, N=3).
// Directed scenarios plus randomized frames checked against a reference
// model that computes the peak directly from the bin values.
// ---------------------------------------------------------------------------
module tb_spectral_peak_finder;

    localparam int SW = 16;
    localparam int BS = 8;
    localparam int SB = 4;
    localparam int F  = 1;
    localparam int N  = SB - F;

    logic            clk;
    logic            reset;
    logic            start;
    logic [BS*SW-1:0] input_mags;
    logic [SW-1:0]   threshold;
    logic            ready;
    logic            done;
    logic [2:0]      peak_index;
    logic [SW-1:0]   peak_mag;
    logic            peak_found;

    int errors = 0;
    int checks = 0;

    spectral_peak_finder #(
        .sample_size(SW),
        .buffer_size(BS),
        .scan_bins  (SB),
        .skip_dc    (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .input_mags(input_mags),
        .threshold (threshold),
        .ready     (ready),
        .done      (done),
        .peak_index(peak_index),
        .peak_mag  (peak_mag),
        .peak_found(peak_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack bins 0..3; the mirrored upper half gets large decoys that must be ignored.
    function automatic logic [BS*SW-1:0] pack(input logic [SW-1:0] b0, input logic [SW-1:0] b1,
                                              input logic [SW-1:0] b2, input logic [SW-1:0] b3);
        logic [BS*SW-1:0] v;
        v = {BS*SW{1'b1}};
        v[0*SW +: SW] = b0;
        v[1*SW +: SW] = b1;
        v[2*SW +: SW] = b2;
        v[3*SW +: SW] = b3;
        return v;
    endfunction

    // Reference: largest eligible value, then the first bin holding it.
    task automatic model(input logic [BS*SW-1:0] m, input logic [SW-1:0] thr,
                         output int idx, output int mag, output int found);
        int vals[$];
        int best;
        vals = {};
        for (int k = F; k < SB; k++) vals.push_back(int'(m[k*SW +: SW]));
        best = 0;
        foreach (vals[i]) if (vals[i] > best) best = vals[i];
        idx = -1;
        foreach (vals[i]) if (idx < 0 && vals[i] == best) idx = i + F;
        mag   = best;
        found = (best > int'(thr)) ? 1 : 0;
    endtask

    // Drive start for one edge; returns in the first cycle after acceptance.
    task automatic start_frame(input logic [BS*SW-1:0] m, input logic [SW-1:0] thr);
        input_mags = m;
        threshold  = thr;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        input_mags = {BS*SW{1'b0}};
        threshold  = 16'd0;
    endtask

    // Count cycles since acceptance until done, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [BS*SW-1:0] m,
                                input logic [SW-1:0] thr, input int lat);
        int e_idx, e_mag, e_found;
        model(m, thr, e_idx, e_mag, e_found);
        check({tag, "_lat"},   lat, N);
        check({tag, "_idx"},   {29'd0, peak_index}, e_idx);
        check({tag, "_mag"},   {16'd0, peak_mag}, e_mag);
        check({tag, "_found"}, {31'd0, peak_found}, e_found);
    endtask

    task automatic run_frame(input string tag, input logic [BS*SW-1:0] m, input logic [SW-1:0] thr);
        int lat;
        check({tag, "_rdy_pre"}, {31'd0, ready}, 1);
        start_frame(m, thr);
        wait_done(lat);
        check_result(tag, m, thr, lat);
        tick();
        check({tag, "_done_post"}, {31'd0, done}, 0);
        check({tag, "_rdy_post"},  {31'd0, ready}, 1);
    endtask

    initial begin
        logic [BS*SW-1:0] fa, fb, fc, fd, fr;
        logic [SW-1:0] tr;
        int lat;
        int seen;

        reset = 1'b1;
        start = 1'b0;
        input_mags = {BS*SW{1'b0}};
        threshold = 16'd0;
        tick();
        tick();
        check("rst_ready", {31'd0, ready}, 1);
        check("rst_done",  {31'd0, done}, 0);
        check("rst_idx",   {29'd0, peak_index}, 0);
        check("rst_mag",   {16'd0, peak_mag}, 0);
        check("rst_found", {31'd0, peak_found}, 0);
        reset = 1'b0;
        tick();

        // Basic peak: bin 0 ignored despite being largest.
        fa = pack(16'd900, 16'd10, 16'd50, 16'd20);
        run_frame("basic", fa, 16'd5);
        check("basic_idx_lit", {29'd0, peak_index}, 2);
        check("basic_mag_lit", {16'd0, peak_mag}, 50);

        // Ties keep lowest index; threshold is strictly greater.
        fb = pack(16'd0, 16'd40, 16'd40, 16'd7);
        run_frame("tie40", fb, 16'd40);
        check("tie40_found_lit", {31'd0, peak_found}, 0);
        run_frame("tie39", fb, 16'd39);
        check("tie39_found_lit", {31'd0, peak_found}, 1);

        // Unsigned comparison.
        fc = pack(16'd0, 16'h0001, 16'hFFFF, 16'h8000);
        run_frame("unsigned", fc, 16'h7FFF);
        check("unsigned_idx_lit", {29'd0, peak_index}, 2);

        // Busy: starts during SCAN and DONE are ignored, next IDLE accepted.
        start_frame(fa, 16'd5);                 // T+1
        input_mags = pack(16'd0, 16'd999, 16'd1, 16'd1);
        start = 1'b1;
        tick();                                 // T+2
        start = 1'b0;
        check("busy_rdy_scan", {31'd0, ready}, 0);
        tick();                                 // T+3
        check("busy_done", {31'd0, done}, 1);
        check_result("busy_first", fa, 16'd5, N);
        input_mags = pack(16'd0, 16'd5, 16'd999, 16'd1);
        start = 1'b1;
        tick();                                 // T+4
        start = 1'b0;
        check("busy_done_low", {31'd0, done}, 0);
        check("busy_rdy", {31'd0, ready}, 1);
        check_result("busy_hold", fa, 16'd5, N);
        fd = pack(16'd0, 16'd1, 16'd2, 16'd3);
        start_frame(fd, 16'd0);
        wait_done(lat);
        check_result("restart", fd, 16'd0, lat);
        check("restart_idx_lit", {29'd0, peak_index}, 3);
        tick();

        // Reset mid-scan abandons the frame.
        start_frame(fa, 16'd5);                 // T+1
        tick();                                 // T+2
        reset = 1'b1;
        tick();                                 // T+3
        reset = 1'b0;
        check("midrst_done",  {31'd0, done}, 0);
        check("midrst_ready", {31'd0, ready}, 1);
        check("midrst_idx",   {29'd0, peak_index}, 0);
        check("midrst_mag",   {16'd0, peak_mag}, 0);
        check("midrst_found", {31'd0, peak_found}, 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        check("midrst_no_done", seen, 0);
        run_frame("after_rst", fc, 16'd3);

        // Reset and start together: nothing latched, no done.
        input_mags = fa;
        threshold = 16'd5;
        start = 1'b1;
        reset = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) seen = 1;
            tick();
        end
        check("rst_start_no_done", seen, 0);
        check("rst_start_ready", {31'd0, ready}, 1);

        // Randomized frames, narrow ranges in some to provoke ties.
        for (int n = 0; n < 40; n++) begin
            fr = {BS*SW{1'b0}};
            for (int k = 0; k < BS; k++) begin
                if (n % 3 == 0) fr[k*SW +: SW] = 16'($urandom_range(0, 3));
                else            fr[k*SW +: SW] = 16'($urandom);
            end
            if (n % 4 == 0) begin
                model(fr, 16'd0, lat, seen, seen);
                tr = 16'(seen);
            end else begin
                tr = 16'($urandom);
            end
            run_frame("rand", fr, tr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spectral_peak_finder.md
# spectral_peak_finder

Sequential peak detector that sits directly downstream of the FFT magnitude stage. It latches one flat, packed vector of per-bin squared magnitudes and scans the bins one per cycle. It reports the largest bin's index and value, plus whether that value exceeds a runtime threshold. The pitch/tone-detection logic consumes its result once per FFT frame.

## Interface
Parameters:
- sample_size, default SAMPLE_SIZE: width of each magnitude word.
- buffer_size, default BUFFER_SIZE: number of bins packed in the input vector; must be a power of two, ≥ 4.
- scan_bins, default buffer_size/2: bins 0..scan_bins-1 are eligible (the mirrored upper half is ignored); 2 ≤ scan_bins ≤ buffer_size.
- skip_dc, default 1: when 1, bin 0 is excluded from the scan.

Ports:
- clk  input  1  clock; everything is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to latch input_mags and begin a scan.
- input_mags  input  buffer_size*sample_size  bin k occupies [sample_size*k + sample_size-1 : sample_size*k].
- threshold  input  sample_size  unsigned detection threshold, sampled together with input_mags.
- ready  output  1  block will accept start this cycle.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
- peak_index  output  $clog2(buffer_size)  index of the largest eligible bin.
- peak_mag  output  sample_size  magnitude of that bin.
- peak_found  output  1  1 when peak_mag > threshold (strictly greater).

## Operation
- Magnitudes and threshold are compared as unsigned: they are sums of squares and must not be treated as signed.
- First bin: F = skip_dc ? 1 : 0. Bin count: N = scan_bins − F.
- States:
  - IDLE: ready=1. On start, copy input_mags and threshold into internal registers, set the running max to bin F (value and index), set the bin counter to F+1, and go to SCAN. If N = 1, go straight to DONE.
  - SCAN: ready=0. Each cycle, compare the latched bin at the counter against the running max and replace the max only if strictly greater, so ties keep the lowest index. Then increment the counter. After bin scan_bins−1 is compared, go to DONE.
  - DONE: lasts one cycle. Drive done=1, load peak_index, peak_mag, and peak_found, then return to IDLE.
- Results hold until the next DONE or reset. input_mags may change freely after start is accepted.
- start while ready=0 is ignored; it is neither queued nor able to corrupt the scan.
- start in the DONE cycle is ignored, because ready=0 there. start in the following IDLE cycle is accepted.
- peak_index and peak_mag report the maximum even when peak_found=0.

## Timing
- Start accepted at rising edge T, when start=1 and ready=1.
- SCAN occupies cycles T+1 .. T+N−1, and DONE is cycle T+N. done=1 and the new outputs appear in that cycle.
- ready returns high at T+N+1. Back-to-back frame period: N+1 cycles.
- Reset values: ready=1, done=0, peak_index=0, peak_mag=0, peak_found=0, state IDLE, internal registers cleared.
- reset has priority over every other input. Asserting reset mid-SCAN abandons the scan: no done pulse and all outputs cleared at the next edge. reset and start in the same cycle leave the block in IDLE with nothing latched.
- The counter never wraps: the last compared index is scan_bins−1, even when scan_bins = buffer_size.

## Test plan
All scenarios use sample_size=16, buffer_size=8, scan_bins=4, skip_dc=1, so N=3.
- Reset: hold reset 2 cycles → ready=1, done=0, peak_index=0, peak_mag=0, peak_found=0.
- Basic peak: bins 0..3 = 900, 10, 50, 20, threshold=5, start at T → done only at T+3 with peak_index=2, peak_mag=50, peak_found=1. Bin 0 is ignored despite 900. ready=1 at T+4.
- Tie and threshold:
  - bins 1..3 = 40, 40, 7, threshold=40 → peak_index=1, peak_mag=40, peak_found=0 (not strictly greater).
  - Same frame with threshold=39 → peak_found=1.
- Unsigned compare: bins 1..3 = 16'h0001, 16'hFFFF, 16'h8000 → peak_index=2, peak_mag=16'hFFFF.
- Busy and re-start:
  - Pulse start again at T+1 and T+3 with different data → ignored; result matches the first frame.
  - Start at T+4 with bins 1..3 = 1, 2, 3 → second done at T+7 with peak_index=3.
- Reset mid-scan: start at T, assert reset at T+2 → no done pulse, outputs 0, ready=1 at T+3. A fresh frame afterwards completes normally.
